// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (generators 7,5 octal).
// Four-state add-compare-select with register-exchange survivors and
// min-subtract path-metric normalization; one symbol in, one bit out per enable.
module viterbi_decoder_k3 #(
   parameter int unsigned TB_DEPTH = 16,
   parameter int unsigned PM_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] d_in,
   output logic       d_out
);

   localparam int unsigned CW = PM_WIDTH + 1;

   logic [PM_WIDTH-1:0] pm        [4];
   logic [TB_DEPTH-1:0] surv      [4];
   logic [CW-1:0]       cand      [4];
   logic [CW-1:0]       diff      [4];
   logic [PM_WIDTH-1:0] pm_next   [4];
   logic [TB_DEPTH-1:0] surv_next [4];
   logic [CW-1:0]       pm_min;
   logic [1:0]          best;
   logic                found;

   // Hamming distance between the received symbol and the branch label p --u-->
   function automatic logic [CW-1:0] branch_metric(input logic [1:0] p, input logic u,
                                                   input logic [1:0] sym);
      logic [1:0] expect_sym;
      logic [1:0] err;
      expect_sym = {u ^ p[1] ^ p[0], u ^ p[0]};
      err        = expect_sym ^ sym;
      return CW'(err[1]) + CW'(err[0]);
   endfunction

   // ACS for every next state, then normalize, saturate and pick the best state
   always_comb begin
      logic [1:0]    ns;
      logic [1:0]    p0;
      logic [1:0]    p1;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      ns     = '0;
      p0     = '0;
      p1     = '0;
      c0     = '0;
      c1     = '0;
      pm_min = '0;
      best   = '0;
      found  = 1'b0;
      for (int unsigned n = 0; n < 4; n++) begin
         ns = 2'(n);
         p0 = {ns[0], 1'b0};
         p1 = {ns[0], 1'b1};
         c0 = CW'(pm[p0]) + branch_metric(p0, ns[1], d_in);
         c1 = CW'(pm[p1]) + branch_metric(p1, ns[1], d_in);
         // strict less-than: ties resolve to the even predecessor
         if (c1 < c0) begin
            cand[n]      = c1;
            surv_next[n] = {surv[p1][TB_DEPTH-2:0], ns[1]};
         end else begin
            cand[n]      = c0;
            surv_next[n] = {surv[p0][TB_DEPTH-2:0], ns[1]};
         end
      end
      pm_min = cand[0];
      for (int unsigned i = 1; i < 4; i++) begin
         if (cand[i] < pm_min) pm_min = cand[i];
      end
      for (int unsigned i = 0; i < 4; i++) begin
         diff[i]    = cand[i] - pm_min;
         pm_next[i] = diff[i][PM_WIDTH] ? '1 : diff[i][PM_WIDTH-1:0];
         if (!found && diff[i] == '0) begin
            best  = 2'(i);
            found = 1'b1;
         end
      end
   end

   // Metric, survivor and output registers; reset biases decoding toward state 0
   always_ff @(posedge clk) begin
      if (rst) begin
         pm[0] <= '0;
         for (int unsigned i = 1; i < 4; i++) pm[i] <= PM_WIDTH'(15);
         for (int unsigned i = 0; i < 4; i++) surv[i] <= '0;
         d_out <= 1'b0;
      end else if (enable) begin
         for (int unsigned i = 0; i < 4; i++) begin
            pm[i]   <= pm_next[i];
            surv[i] <= surv_next[i];
         end
         d_out <= surv_next[best][TB_DEPTH-1];
      end
   end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench for viterbi_decoder_k3: random and directed data streams are
// convolutionally encoded here, optionally corrupted, and the decoded bit is
// compared with the source bit delayed by TB_DEPTH-1 enabled symbols.
module tb_viterbi_decoder_k3;

   localparam int TBD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] d_in = 2'b00;
   logic       d_out;

   int errors = 0;
   int checks = 0;

   bit         sent[$];
   logic [1:0] enc_state;
   logic       held;
   bit         stream[256];
   bit         pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

   viterbi_decoder_k3 #(.TB_DEPTH(TBD), .PM_WIDTH(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .d_in   (d_in),
      .d_out  (d_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      enable = 1'($urandom);
      d_in   = 2'($urandom);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      enable    = 1'b0;
      sent.delete();
      enc_state = 2'b00;
      held      = 1'b0;
      check("reset_dout", int'(d_out), 0);
      check("reset_pm0", int'(dut.pm[0]), 0);
      check("reset_pm3", int'(dut.pm[3]), 15);
   endtask

   // encode u with generator masks over {u, u[k-1], u[k-2]}, flip bits per err
   task automatic send(input bit u, input logic [1:0] err, input string tag);
      logic [2:0] h;
      logic [1:0] sym;
      int         k;
      bit         exp;
      h         = {u, enc_state};
      sym       = {^(h & 3'b111), ^(h & 3'b101)};
      enc_state = {u, enc_state[1]};
      sent.push_back(u);
      k   = sent.size() - 1;
      exp = (k >= TBD - 1) ? sent[k - (TBD - 1)] : 1'b0;
      enable = 1'b1;
      d_in   = sym ^ err;
      @(posedge clk);
      #1;
      enable = 1'b0;
      held   = exp;
      check(tag, int'(d_out), int'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         enable = 1'b0;
         d_in   = 2'($urandom);
         @(posedge clk);
         #1;
         check("gap_hold", int'(d_out), int'(held));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) stream[i] = 1'($urandom);
      @(posedge clk);
      #1;

      // all-zero stream: output and state-0 metric stay at zero
      do_reset();
      for (int i = 0; i < 40; i++) begin
         send(1'b0, 2'b00, "zeros");
         check("zeros_pm0", int'(dut.pm[0]), 0);
      end

      // repeating directed pattern
      do_reset();
      for (int i = 0; i < 48; i++) send(pat[i % 8], 2'b00, "pattern");

      // random stream with g0 parity flipped on every 8th symbol
      do_reset();
      for (int i = 0; i < 256; i++) send(stream[i], (i % 8 == 7) ? 2'b10 : 2'b00, "errs");

      // same stream with random enable gaps
      do_reset();
      for (int i = 0; i < 256; i++) begin
         if ($urandom_range(3) == 0) idle(int'($urandom_range(5, 1)));
         send(stream[i], (i % 8 == 7) ? 2'b10 : 2'b00, "gaps");
      end

      // mid-stream reset, then a fresh stream from encoder state 0
      do_reset();
      for (int i = 0; i < 100; i++) send(stream[i], 2'b00, "pre_rst");
      do_reset();
      for (int i = 0; i < 60; i++) send(1'($urandom), 2'b00, "post_rst");

      // both bits of one symbol inverted in an all-zero stream
      do_reset();
      for (int i = 0; i < 50; i++) send(1'b0, (i == 20) ? 2'b11 : 2'b00, "double_err");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
